// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared encodings for the bit-serial add/subtract engine.
package serial_addsub_ctrl_pkg;

    // Encoding 2'd3 is unused and decodes as idle wherever state is examined.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// Single-bit full adder, time-shared by the serial engine across all bit positions.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Ca
);

    assign S  = A ^ B ^ Ci;
    assign Ca = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: operands stream LSB-first through one full adder.
// Handshakes: a transfer occurs on a rising edge where valid && ready; producers hold data until then.
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   s_q;
    logic               co_q;
    logic               ov_q;

    logic [WIDTH-1:0]   b_load_d;
    logic               sum_bit;
    logic               carry_d;

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    assign b_load_d = (op_sub == OP_SUB) ? ~B : B;

    fullAdder u_fa (
        .A  (a_sr_q[0]),
        .B  (b_sr_q[0]),
        .Ci (carry_q),
        .S  (sum_bit),
        .Ca (carry_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    s_q     <= {sum_bit, s_q[WIDTH-1:1]};
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // carry_q here is the carry into the MSB.
                        ov_q    <= carry_q ^ carry_d;
                        co_q    <= carry_d;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        a_sr_q  <= A;
                        b_sr_q  <= b_load_d;
                        carry_q <= (op_sub != OP_ADD);
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q != ST_RUN) && (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign S         = s_q;
    assign Co        = co_q;
    assign Ov        = ov_q;

endmodule
